// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, shift a command byte out on
// device clocks, check the device ACK. Lines are only ever pulled low via output enables.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES = 1500000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe_out,
   output logic       ps2_data_oe_out,
   output logic       busy_out,
   output logic       done_out,
   output logic       error_out
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] INH_DATA = CNT_W'(INHIBIT_CYCLES - 2);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic             INH_ONE  = (INHIBIT_CYCLES == 1);

   typedef enum logic [2:0] {
      IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, RECOVER
   } state_t;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   state_t                 state_r, state_s;
   logic [CNT_W-1:0]       cnt_r, cnt_s;
   logic [8:0]             shift_r, shift_s;
   logic [3:0]             bit_cnt_r, bit_cnt_s;
   logic [SYNC_STAGES-1:0] clk_sync_r, data_sync_r;
   logic                   clk_prev_r;
   logic                   clk_oe_r, clk_oe_s, data_oe_r, data_oe_s;
   logic                   ready_r, ready_s, busy_r, busy_s;
   logic                   done_r, done_s, error_r, error_s;
   logic                   clk_cur_s, data_cur_s, fall_s, timeout_s;

   assign clk_cur_s  = clk_sync_r[SYNC_STAGES-1];
   assign data_cur_s = data_sync_r[SYNC_STAGES-1];
   assign fall_s     = clk_prev_r & ~clk_cur_s;
   assign timeout_s  = (cnt_r == TO_LAST);

   // Synchronize the raw bus lines; idle level is high.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         clk_sync_r  <= {SYNC_STAGES{1'b1}};
         data_sync_r <= {SYNC_STAGES{1'b1}};
         clk_prev_r  <= 1'b1;
      end else begin
         clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk_in};
         data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data_in};
         clk_prev_r  <= clk_cur_s;
      end
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      shift_s   = shift_r;
      bit_cnt_s = bit_cnt_r;
      clk_oe_s  = 1'b0;
      data_oe_s = data_oe_r;
      done_s    = 1'b0;
      error_s   = 1'b0;
      case (state_r)
         IDLE: begin
            data_oe_s = 1'b0;
            if (valid_in && ready_r) begin
               shift_s   = {odd_parity(data_in), data_in};
               cnt_s     = {CNT_W{1'b0}};
               bit_cnt_s = 4'd0;
               clk_oe_s  = 1'b1;
               data_oe_s = INH_ONE;
               state_s   = INHIBIT;
            end else begin
               state_s = IDLE;
            end
         end
         INHIBIT: begin
            clk_oe_s = 1'b1;
            cnt_s    = cnt_r + CNT_W'(1);
            // Start bit goes low one cycle before the clock is released.
            if (cnt_r == INH_DATA) begin
               data_oe_s = 1'b1;
            end else begin
               data_oe_s = data_oe_r;
            end
            if (cnt_r == INH_LAST) begin
               clk_oe_s  = 1'b0;
               data_oe_s = 1'b1;
               cnt_s     = {CNT_W{1'b0}};
               state_s   = REQ;
            end else begin
               state_s = INHIBIT;
            end
         end
         REQ, SEND: begin
            cnt_s = cnt_r + CNT_W'(1);
            if (fall_s) begin
               cnt_s = {CNT_W{1'b0}};
               if (state_r == SEND && bit_cnt_r == 4'd9) begin
                  data_oe_s = 1'b0;
                  state_s   = ACK;
               end else begin
                  data_oe_s = ~shift_r[0];
                  shift_s   = {1'b1, shift_r[8:1]};
                  bit_cnt_s = bit_cnt_r + 4'd1;
                  state_s   = SEND;
               end
            end else if (timeout_s) begin
               data_oe_s = 1'b0;
               error_s   = 1'b1;
               state_s   = IDLE;
            end else begin
               state_s = state_r;
            end
         end
         ACK: begin
            cnt_s = cnt_r + CNT_W'(1);
            if (fall_s) begin
               cnt_s = {CNT_W{1'b0}};
               if (!data_cur_s) begin
                  state_s = WAIT_IDLE;
               end else begin
                  error_s = 1'b1;
                  state_s = RECOVER;
               end
            end else if (timeout_s) begin
               error_s = 1'b1;
               state_s = IDLE;
            end else begin
               state_s = ACK;
            end
         end
         WAIT_IDLE: begin
            cnt_s = cnt_r + CNT_W'(1);
            if (clk_cur_s && data_cur_s) begin
               done_s  = 1'b1;
               state_s = IDLE;
            end else if (timeout_s) begin
               error_s = 1'b1;
               state_s = IDLE;
            end else begin
               state_s = WAIT_IDLE;
            end
         end
         RECOVER: begin
            data_oe_s = 1'b0;
            state_s   = IDLE;
         end
         default: begin
            data_oe_s = 1'b0;
            state_s   = IDLE;
         end
      endcase
      // Hold ready low during the done/error pulse cycle.
      ready_s = (state_s == IDLE) && !done_s && !error_s;
      busy_s  = ~ready_s;
   end

   // State, datapath and output registers.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_r   <= IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         shift_r   <= 9'd0;
         bit_cnt_r <= 4'd0;
         clk_oe_r  <= 1'b0;
         data_oe_r <= 1'b0;
         ready_r   <= 1'b1;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         error_r   <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         shift_r   <= shift_s;
         bit_cnt_r <= bit_cnt_s;
         clk_oe_r  <= clk_oe_s;
         data_oe_r <= data_oe_s;
         ready_r   <= ready_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         error_r   <= error_s;
      end
   end

   assign ready_out       = ready_r;
   assign busy_out        = busy_r;
   assign done_out        = done_r;
   assign error_out       = error_r;
   assign ps2_clk_oe_out  = clk_oe_r;
   assign ps2_data_oe_out = data_oe_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on open-collector lines.
module tb_ps2_host_tx;

   localparam int INH  = 40;
   localparam int TO   = 400;
   localparam int HALF = 15;

   logic       clk = 1'b0;
   logic       rst, valid;
   logic [7:0] din;
   logic       ready, clk_oe, data_oe, busy, done, err;
   logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
   logic       ps2_clk_line, ps2_data_line;

   int checks = 0, failures = 0;
   int done_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0;
   int cyc = 0, done_cyc = 0, acc_cyc = 0;

   always #5 clk = ~clk;

   assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
   assign ps2_data_line = ~(data_oe | dev_data_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
      .clk_in(clk), .rst_in(rst), .data_in(din), .valid_in(valid), .ready_out(ready),
      .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
      .ps2_clk_oe_out(clk_oe), .ps2_data_oe_out(data_oe),
      .busy_out(busy), .done_out(done), .error_out(err)
   );

   // Pulse and handshake monitor.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
      if (err) err_cnt <= err_cnt + 1;
      if (done && err) both_cnt <= both_cnt + 1;
      if (valid && ready) begin acc_cnt <= acc_cnt + 1; acc_cyc <= cyc; end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      din = b; valid = 1'b1;
      tick(1);
      valid = 1'b0;
   endtask

   // Measure the inhibit phase; returns at the first cycle with the clock released.
   task automatic wait_req(output int len, output logic d_last, output logic d_prev);
      logic seen;
      len = 0; d_last = 1'b0; d_prev = 1'b0; seen = 1'b0;
      for (int k = 0; k < INH * 4; k++) begin
         if (clk_oe) begin
            len++; d_prev = d_last; d_last = data_oe; seen = 1'b1;
         end else if (seen) begin
            break;
         end
         tick(1);
      end
   endtask

   // Device: generate nfall clocks, sample data in each high phase, optionally ACK on edge 11.
   task automatic dev_frame(input int nfall, input logic ack, output logic [10:0] fr);
      fr = '1;
      tick(5);
      fr[0] = ps2_data_line;
      for (int e = 1; e <= nfall; e++) begin
         if (e == 11 && ack) dev_data_low = 1'b1;
         dev_clk_low = 1'b1; tick(HALF);
         dev_clk_low = 1'b0; tick(HALF);
         if (e <= 10) fr[e] = ps2_data_line;
      end
      dev_data_low = 1'b0;
   endtask

   task automatic wait_end(input int d0, input int e0);
      for (int k = 0; k < 100; k++) begin
         if (done_cnt != d0 || err_cnt != e0) break;
         tick(1);
      end
   endtask

   task automatic check_frame(input string tag, input logic [10:0] fr,
                              input logic [7:0] b, input logic par);
      check({tag, "_start"}, {31'd0, fr[0]}, 32'd0);
      check({tag, "_data"}, {24'd0, fr[8:1]}, {24'd0, b});
      check({tag, "_par"}, {31'd0, fr[9]}, {31'd0, par});
      check({tag, "_stop"}, {31'd0, fr[10]}, 32'd1);
   endtask

   task automatic xfer(input logic [7:0] b, input logic ack, output logic [10:0] fr);
      int len, d0, e0;
      logic dl, dp;
      d0 = done_cnt; e0 = err_cnt;
      send(b);
      wait_req(len, dl, dp);
      dev_frame(11, ack, fr);
      wait_end(d0, e0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   initial begin
      logic [10:0] fr;
      int len, d0, e0, a0, k;
      logic dl, dp;

      rst = 1'b1; valid = 1'b0; din = 8'h00;
      tick(3);
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_clk_oe", {31'd0, clk_oe}, 32'd0);
      check("rst_data_oe", {31'd0, data_oe}, 32'd0);
      rst = 1'b0;
      tick(2);

      // 1: 0xED, full handshake
      d0 = done_cnt; e0 = err_cnt;
      send(8'hED);
      wait_req(len, dl, dp);
      check("t1_inh_len", len, INH);
      check("t1_start_last", {31'd0, dl}, 32'd1);
      check("t1_start_prev", {31'd0, dp}, 32'd0);
      dev_frame(11, 1'b1, fr);
      wait_end(d0, e0);
      check_frame("t1", fr, 8'hED, 1'b1);
      check("t1_done", done_cnt - d0, 32'd1);
      check("t1_err", err_cnt - e0, 32'd0);
      tick(1);
      check("t1_ready", {31'd0, ready}, 32'd1);

      // 2: parity 0 and parity 1
      d0 = done_cnt; e0 = err_cnt;
      xfer(8'h01, 1'b1, fr);
      check_frame("t2a", fr, 8'h01, 1'b0);
      tick(2);
      xfer(8'h00, 1'b1, fr);
      check_frame("t2b", fr, 8'h00, 1'b1);
      check("t2_done", done_cnt - d0, 32'd2);
      check("t2_err", err_cnt - e0, 32'd0);
      tick(2);

      // 3: missing ACK
      d0 = done_cnt; e0 = err_cnt;
      xfer(8'hA5, 1'b0, fr);
      check_frame("t3", fr, 8'hA5, 1'b1);
      tick(2);
      check("t3_err", err_cnt - e0, 32'd1);
      check("t3_done", done_cnt - d0, 32'd0);
      check("t3_clk_oe", {31'd0, clk_oe}, 32'd0);
      check("t3_data_oe", {31'd0, data_oe}, 32'd0);
      check("t3_ready", {31'd0, ready}, 32'd1);

      // 4: device never clocks
      d0 = done_cnt;
      send(8'h3C);
      wait_req(len, dl, dp);
      k = 0;
      while (k < TO + 50) begin
         tick(1);
         k++;
         if (err) break;
      end
      check("t4_latency", k, TO);
      check("t4_clk_oe", {31'd0, clk_oe}, 32'd0);
      check("t4_data_oe", {31'd0, data_oe}, 32'd0);
      tick(1);
      check("t4_ready", {31'd0, ready}, 32'd1);
      check("t4_done", done_cnt - d0, 32'd0);
      tick(2);

      // 5: reset after five data bits
      send(8'h5A);
      wait_req(len, dl, dp);
      dev_frame(5, 1'b0, fr);
      d0 = done_cnt; e0 = err_cnt;
      check("t5_pre_data_oe", {31'd0, data_oe}, 32'd0);
      check("t5_pre_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick(1);
      check("t5_clk_oe", {31'd0, clk_oe}, 32'd0);
      check("t5_data_oe", {31'd0, data_oe}, 32'd0);
      check("t5_ready", {31'd0, ready}, 32'd1);
      rst = 1'b0;
      tick(20);
      check("t5_done", done_cnt - d0, 32'd0);
      check("t5_err", err_cnt - e0, 32'd0);
      d0 = done_cnt;
      xfer(8'hFF, 1'b1, fr);
      check_frame("t5", fr, 8'hFF, 1'b1);
      check("t5_done_after", done_cnt - d0, 32'd1);
      tick(2);

      // 6: valid held high across two transfers
      d0 = done_cnt; a0 = acc_cnt;
      din = 8'hF4; valid = 1'b1;
      tick(1);
      din = 8'hF5;
      wait_req(len, dl, dp);
      dev_frame(11, 1'b1, fr);
      check_frame("t6a", fr, 8'hF4, 1'b0);
      check("t6_acc_during", acc_cnt - a0, 32'd1);
      wait_end(d0, err_cnt);
      check("t6_acc_at_done", acc_cnt - a0, 32'd1);
      for (int i = 0; i < 10; i++) begin
         if (busy) break;
         tick(1);
      end
      valid = 1'b0;
      check("t6_order", {31'd0, acc_cyc > done_cyc}, 32'd1);
      d0 = done_cnt;
      wait_req(len, dl, dp);
      dev_frame(11, 1'b1, fr);
      wait_end(d0, err_cnt);
      check_frame("t6b", fr, 8'hF5, 1'b1);
      check("t6_acc_total", acc_cnt - a0, 32'd2);
      check("t6_done", done_cnt - d0, 32'd1);

      check("both_pulses", both_cnt, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
